// File: rtl/mux_reg_src_pipe.sv
// Write-back source selector: picks one of NUM_IN channels or a constant and
// holds the result in a 2-entry in-order skid buffer with valid/ready on both sides.
module mux_reg_src_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_IN = 7,
  parameter int unsigned SEL_W  = 3,
  parameter logic [DATA_W-1:0] DEFAULT_VAL = DATA_W'(227)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        data_out,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     sel_err,
  input  logic                     err_clr
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [DATA_W-1:0]   head_data_q, head_data_d;
  logic [SEL_W-1:0]    head_sel_q, head_sel_d;
  logic [DATA_W-1:0]   tail_data_q, tail_data_d;
  logic [SEL_W-1:0]    tail_sel_q, tail_sel_d;
  logic                sel_err_q, sel_err_d;

  logic [DATA_W-1:0]   sel_val;
  logic                sel_oob;
  logic                push;
  logic                pop;

  // Channel k (1-based) lives at data_in[k*DATA_W-1 -: DATA_W]; code 0 is the constant.
  always_comb begin
    sel_val = DEFAULT_VAL;
    for (int k = 1; k <= int'(NUM_IN); k++) begin
      if (sel == SEL_W'(k)) begin
        sel_val = data_in[(k-1)*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_oob   = (sel > SEL_W'(NUM_IN));
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sel_d  = head_sel_q;
    tail_data_d = tail_data_q;
    tail_sel_d  = tail_sel_q;
    case (state_q)
      StEmpty: begin
        if (push) begin
          head_data_d = sel_val;
          head_sel_d  = sel;
          state_d     = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          head_data_d = sel_val;
          head_sel_d  = sel;
        end else if (push) begin
          tail_data_d = sel_val;
          tail_sel_d  = sel;
          state_d     = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          head_data_d = tail_data_q;
          head_sel_d  = tail_sel_q;
          state_d     = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  assign in_ready_d = (state_d != StFull);

  // A fresh out-of-range accept wins over a same-cycle clear.
  always_comb begin
    sel_err_d = sel_err_q;
    if (push && sel_oob) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      head_data_q <= '0;
      head_sel_q  <= '0;
      tail_data_q <= '0;
      tail_sel_q  <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      head_data_q <= head_data_d;
      head_sel_q  <= head_sel_d;
      tail_data_q <= tail_data_d;
      tail_sel_q  <= tail_sel_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign data_out = head_data_q;
  assign out_sel  = head_sel_q;
  assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_mux_reg_src_pipe.sv
// Bench for mux_reg_src_pipe: three parameterisations share one stimulus stream and are
// checked every cycle against a queue-based model, plus directed literal checks.
module tb_mux_reg_src_pipe;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         out_ready;
  logic         err_clr;
  logic [2:0]   sel;
  logic [223:0] data_in;

  logic        rdy_a, ov_a, se_a;
  logic [31:0] do_a;
  logic [2:0]  os_a;
  logic        rdy_b, ov_b, se_b;
  logic [15:0] do_b;
  logic [1:0]  os_b;
  logic        rdy_c, ov_c, se_c;
  logic [31:0] do_c;
  logic [2:0]  os_c;

  always #5 clk = ~clk;

  mux_reg_src_pipe u_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_a), .sel(sel),
    .data_in(data_in), .out_valid(ov_a), .out_ready(out_ready), .data_out(do_a),
    .out_sel(os_a), .sel_err(se_a), .err_clr(err_clr)
  );

  mux_reg_src_pipe #(.DATA_W(16), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(16'hBEEF)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_b), .sel(sel[1:0]),
    .data_in(data_in[47:0]), .out_valid(ov_b), .out_ready(out_ready), .data_out(do_b),
    .out_sel(os_b), .sel_err(se_b), .err_clr(err_clr)
  );

  mux_reg_src_pipe #(.DATA_W(32), .NUM_IN(5), .SEL_W(3), .DEFAULT_VAL(32'd227)) u_c (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_c), .sel(sel),
    .data_in(data_in[159:0]), .out_valid(ov_c), .out_ready(out_ready), .data_out(do_c),
    .out_sel(os_c), .sel_err(se_c), .err_clr(err_clr)
  );

  typedef struct {
    logic [31:0] d;
    logic [2:0]  s;
  } ent_t;

  ent_t qa[$], qb[$], qc[$];
  ent_t la, lb, lc;
  bit   m_rdy;
  bit   ea, eb, ec;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_val(input int s, input int nin, input int dw,
                                          input logic [31:0] dflt, input logic [223:0] din);
    logic [223:0] t;
    logic [31:0]  m;
    if (s == 0 || s > nin) return dflt;
    t = din >> ((s - 1) * dw);
    m = (dw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << dw) - 32'h1);
    return t[31:0] & m;
  endfunction

  task automatic mreset();
    qa.delete(); qb.delete(); qc.delete();
    la = '{32'h0, 3'h0}; lb = '{32'h0, 3'h0}; lc = '{32'h0, 3'h0};
    m_rdy = 1'b1;
    ea = 1'b0; eb = 1'b0; ec = 1'b0;
  endtask

  // Model: queue occupancy decides ready; entries carry the value the rules say is selected.
  task automatic mstep();
    bit acc, pop;
    int s3, s2;
    acc = in_valid && m_rdy;
    pop = (qa.size() > 0) && out_ready;
    s3  = int'(sel);
    s2  = int'(sel[1:0]);
    if (pop) begin
      void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
    end
    if (acc) begin
      qa.push_back('{exp_val(s3, 7, 32, 32'd227, data_in), sel});
      qb.push_back('{exp_val(s2, 3, 16, 32'h0000_BEEF, data_in), {1'b0, sel[1:0]}});
      qc.push_back('{exp_val(s3, 5, 32, 32'd227, data_in), sel});
    end
    if (acc && s3 > 7) ea = 1'b1; else if (err_clr) ea = 1'b0;
    if (acc && s2 > 3) eb = 1'b1; else if (err_clr) eb = 1'b0;
    if (acc && s3 > 5) ec = 1'b1; else if (err_clr) ec = 1'b0;
    m_rdy = (qa.size() < 2);
    if (qa.size() > 0) begin
      la = qa[0]; lb = qb[0]; lc = qc[0];
    end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) mreset();
      else mstep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("a_in_ready", {31'h0, rdy_a}, {31'h0, m_rdy});
        chk("a_out_valid", {31'h0, ov_a}, {31'h0, qa.size() > 0});
        chk("a_data_out", do_a, (qa.size() > 0) ? qa[0].d : la.d);
        chk("a_out_sel", {29'h0, os_a}, {29'h0, (qa.size() > 0) ? qa[0].s : la.s});
        chk("a_sel_err", {31'h0, se_a}, {31'h0, ea});
        chk("b_in_ready", {31'h0, rdy_b}, {31'h0, m_rdy});
        chk("b_out_valid", {31'h0, ov_b}, {31'h0, qb.size() > 0});
        chk("b_data_out", {16'h0, do_b}, (qb.size() > 0) ? qb[0].d : lb.d);
        chk("b_out_sel", {30'h0, os_b}, {29'h0, (qb.size() > 0) ? qb[0].s : lb.s});
        chk("b_sel_err", {31'h0, se_b}, {31'h0, eb});
        chk("c_in_ready", {31'h0, rdy_c}, {31'h0, m_rdy});
        chk("c_out_valid", {31'h0, ov_c}, {31'h0, qc.size() > 0});
        chk("c_data_out", do_c, (qc.size() > 0) ? qc[0].d : lc.d);
        chk("c_out_sel", {29'h0, os_c}, {29'h0, (qc.size() > 0) ? qc[0].s : lc.s});
        chk("c_sel_err", {31'h0, se_c}, {31'h0, ec});
      end
    end
  end

  // Holds in_valid with the given select until an accepting edge, bounded.
  task automatic offer(input logic [2:0] s);
    bit ok;
    sel      = s;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = rdy_a;
      @(posedge clk);
      #2;
    end
    chk("offer_accepted", {31'h0, ok}, 32'h1);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    sel       = '0;
    data_in   = '0;
    for (int k = 1; k <= 7; k++) data_in[(k-1)*32 +: 32] = 32'h1000_0000 + k;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", {31'h0, rdy_a}, 32'h1);
    chk("rst_out_valid", {31'h0, ov_a}, 32'h0);
    chk("rst_data_out", do_a, 32'h0);
    chk("rst_sel_err", {31'h0, se_c}, 32'h0);
    reset_n = 1'b1;
    idle_cycle();

    // Streaming at full rate exercises push+pop at occupancy one.
    offer(3'd0); chk("stream_s0", do_a, 32'd227);       chk("stream_rdy0", {31'h0, rdy_a}, 32'h1);
    offer(3'd1); chk("stream_s1", do_a, 32'h1000_0001); chk("stream_ov1", {31'h0, ov_a}, 32'h1);
    offer(3'd3); chk("stream_s3", do_a, 32'h1000_0003); chk("stream_rdy3", {31'h0, rdy_a}, 32'h1);
    offer(3'd7); chk("stream_s7", do_a, 32'h1000_0007); chk("stream_os7", {29'h0, os_a}, 32'h7);
    in_valid = 1'b0;
    idle_cycle();
    chk("drain_empty", {31'h0, ov_a}, 32'h0);
    chk("empty_hold", do_a, 32'h1000_0007);

    // Back-pressure: two absorbed, third held off until a pop.
    out_ready = 1'b0;
    offer(3'd2);
    offer(3'd4);
    sel = 3'd5;
    idle_cycle();
    idle_cycle();
    chk("bp_full_rdy", {31'h0, rdy_a}, 32'h0);
    chk("bp_head", do_a, 32'h1000_0002);
    out_ready = 1'b1;
    idle_cycle();
    chk("bp_pop1", do_a, 32'h1000_0004);
    chk("bp_rdy_back", {31'h0, rdy_a}, 32'h1);
    idle_cycle();
    chk("bp_third", do_a, 32'h1000_0005);
    in_valid = 1'b0;
    idle_cycle();

    // Out-of-range select on the NUM_IN=5 instance.
    offer(3'd6);
    chk("oob_data", do_c, 32'd227);
    chk("oob_sel", {29'h0, os_c}, 32'h6);
    chk("oob_err", {31'h0, se_c}, 32'h1);
    err_clr = 1'b1;
    offer(3'd6);
    chk("oob_set_beats_clr", {31'h0, se_c}, 32'h1);
    in_valid = 1'b0;
    idle_cycle();
    chk("oob_clr", {31'h0, se_c}, 32'h0);
    err_clr = 1'b0;
    idle_cycle();

    // Asynchronous reset while full.
    out_ready = 1'b0;
    offer(3'd1);
    offer(3'd2);
    in_valid = 1'b0;
    chk("mr_full_rdy", {31'h0, rdy_a}, 32'h0);
    chk("mr_full_ov", {31'h0, ov_a}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mr_rdy", {31'h0, rdy_a}, 32'h1);
    chk("mr_ov", {31'h0, ov_a}, 32'h0);
    chk("mr_data", do_a, 32'h0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      idle_cycle();
      chk("mr_no_stale", {31'h0, ov_a}, 32'h0);
    end

    // Narrow instance slicing.
    data_in[47:0] = {16'hC333, 16'hB222, 16'hA111};
    offer(3'd0); chk("b_default", {16'h0, do_b}, 32'h0000_BEEF);
    offer(3'd2); chk("b_ch2", {16'h0, do_b}, 32'h0000_B222);
    offer(3'd3); chk("b_ch3", {16'h0, do_b}, 32'h0000_C333);
    in_valid = 1'b0;
    idle_cycle();

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #2;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel       = 3'($urandom_range(0, 7));
      err_clr   = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 7; k++) data_in[k*32 +: 32] = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
    end
    in_valid = 1'b0;
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_reg_src_pipe.md
# mux_reg_src_pipe

Parametrised, pipelined successor to the register-file write-back source selector. It picks one of `NUM_IN` data channels, or a fixed default constant, per transaction. The result is registered through a 2-entry skid buffer with valid/ready handshakes on both sides. It sits between the datapath result buses and the register-file write port, so the control unit can issue a select and data in the same cycle and tolerate write-port back-pressure without losing transactions.

## Interface
- `DATA_W`, 32, width of every data channel and of `data_out`
- `NUM_IN`, 7, number of data channels, numbered 1..`NUM_IN`; select code 0 is reserved for the constant
- `SEL_W`, 3, select width; must satisfy 2^`SEL_W` > `NUM_IN`
- `DEFAULT_VAL`, 227, constant driven for select 0 and for any out-of-range select

- `clk`  in  1  single clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream presents a transaction
- `in_ready`  out  1  block can accept; a transfer occurs on a rising edge with `in_valid` & `in_ready`
- `sel`  in  `SEL_W`  source select for the offered transaction
- `data_in`  in  `NUM_IN*DATA_W`  flattened channels; channel k occupies bits [k*`DATA_W`-1 : (k-1)*`DATA_W`]
- `out_valid`  out  1  `data_out`/`out_sel` hold a valid transaction
- `out_ready`  in  1  downstream consumes; a pop occurs on a rising edge with `out_valid` & `out_ready`
- `data_out`  out  `DATA_W`  selected value of the head entry
- `out_sel`  out  `SEL_W`  select code that produced the head entry
- `sel_err`  out  1  sticky flag: an accepted transaction had `sel` > `NUM_IN`
- `err_clr`  in  1  synchronous clear of `sel_err`

## Operation
- Selection is evaluated combinationally at the input and captured on acceptance:
  - `sel`=0 gives `DEFAULT_VAL`.
  - 1 ≤ `sel` ≤ `NUM_IN` gives channel `sel`.
  - `sel` > `NUM_IN` gives `DEFAULT_VAL` and sets `sel_err`.
- `data_in` is sampled only at the accepting edge. Later changes do not affect stored entries.
- Storage is a 2-entry in-order buffer with occupancy 0, 1 or 2, implemented as states EMPTY, ONE and FULL:
  - EMPTY, push: ONE.
  - ONE, push without pop: FULL.
  - ONE, pop without push: EMPTY.
  - ONE, push and pop together: ONE. The new entry becomes head and the old head leaves.
  - FULL, pop: ONE. No push is possible because `in_ready`=0.
- `in_ready` is registered. It is 1 in EMPTY and ONE, and 0 in FULL.
- `out_valid` is 1 in ONE and FULL.
- `data_out`/`out_sel` always show the oldest entry. They hold stable while `out_valid`=1 and `out_ready`=0.
- `sel_err` priority: a set from an accepted out-of-range select in the same cycle beats `err_clr`.
- When the buffer is empty, `data_out` holds its last value. It is not forced to zero.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - `out_valid`=0, `data_out`=0, `out_sel`=0, `sel_err`=0, `in_ready`=1, state EMPTY.
  - Any in-flight entries are discarded.
  - Deassertion is taken synchronously. The first accept can occur at the first rising edge after `reset_n` rises.
- Latency: a transaction accepted at edge N appears on `out_valid`/`data_out` immediately after edge N (1 cycle).
- Throughput: one transaction per cycle while `out_ready`=1.
- Back-pressure:
  - With `out_ready`=0, two transactions are absorbed; `in_ready` falls after the second accept.
  - `in_ready` returns to 1 after the edge where the first pop occurs.
- `in_valid` with `in_ready`=0 is ignored. Upstream must hold the transaction.
- `err_clr` takes effect at the next edge. `sel_err` is visible the cycle after the offending accept.

## Test plan
- Reset then stream with `out_ready`=1: offer `sel`=0,1,3,7 with channel k = 32'h1000_0000+k. Required: `data_out`=227, 32'h1000_0001, 32'h1000_0003, 32'h1000_0007 on consecutive cycles, one cycle after each accept, with `in_ready` constantly 1.
- Back-pressure: hold `out_ready`=0 and offer `sel`=2 then `sel`=4. Required: both are accepted and `in_ready`=0 afterward; a third offer is not accepted. Releasing `out_ready` pops channel 2 then channel 4 in order, and the third offer is then accepted.
- Simultaneous push/pop at occupancy 1: required occupancy stays 1, `out_valid` stays 1, and data order is preserved.
- Out-of-range select with `NUM_IN`=5 and `sel`=6: required `data_out`=227, `out_sel`=6, `sel_err`=1. Then assert `err_clr` together with another `sel`=6 accept: `sel_err` stays 1. Assert `err_clr` alone: `sel_err`=0.
- Mid-operation reset: with FULL and `out_valid`=1, pulse `reset_n` low between clock edges. Required: outputs go to their reset values immediately (`in_ready`=1, `out_valid`=0, `data_out`=0), and no stale entry appears afterward.
- Parameter sweep (`DATA_W`=16, `NUM_IN`=3, `SEL_W`=2, `DEFAULT_VAL`=16'hBEEF): required correct channel slicing and `data_out`=16'hBEEF for `sel`=0.
